// File: rtl/single_display.sv
// Freezes 16 bits of a switch-selected CPU debug value once per scan frame and drives a 4-digit 7-segment display.
// Outputs are registered and trail digitIdx/shown by one cycle. There is no backpressure: the display free-runs.
module single_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic        half,
  input  logic [31:0] currentPC,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  input  logic [31:0] s3,
  input  logic [31:0] s4,
  input  logic [31:0] s5,
  input  logic [31:0] s6,
  input  logic [31:0] s7,
  input  logic [31:0] t0,
  input  logic [31:0] t1,
  input  logic [31:0] t2,
  input  logic [31:0] t3,
  input  logic [31:0] t4,
  input  logic [31:0] t5,
  input  logic [31:0] t6,
  input  logic [31:0] t7,
  input  logic [31:0] t8,
  input  logic [31:0] t9,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] divCnt;
  logic [1:0]       digitIdx;
  logic [15:0]      shown;
  logic             shownHalf;
  logic             shownBad;
  logic [31:0]      value;
  logic             tick;
  logic             frameWrap;

  function automatic logic [6:0] hexSeg(input logic [3:0] nib);
    case (nib)
      4'h0: hexSeg = 7'b1000000;
      4'h1: hexSeg = 7'b1111001;
      4'h2: hexSeg = 7'b0100100;
      4'h3: hexSeg = 7'b0110000;
      4'h4: hexSeg = 7'b0011001;
      4'h5: hexSeg = 7'b0010010;
      4'h6: hexSeg = 7'b0000010;
      4'h7: hexSeg = 7'b1111000;
      4'h8: hexSeg = 7'b0000000;
      4'h9: hexSeg = 7'b0010000;
      4'hA: hexSeg = 7'b0001000;
      4'hB: hexSeg = 7'b0000011;
      4'hC: hexSeg = 7'b1000110;
      4'hD: hexSeg = 7'b0100001;
      4'hE: hexSeg = 7'b0000110;
      default: hexSeg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    value = 32'd0;
    case (sel)
      5'd0:  value = currentPC;
      5'd1:  value = s0;
      5'd2:  value = s1;
      5'd3:  value = s2;
      5'd4:  value = s3;
      5'd5:  value = s4;
      5'd6:  value = s5;
      5'd7:  value = s6;
      5'd8:  value = s7;
      5'd9:  value = t0;
      5'd10: value = t1;
      5'd11: value = t2;
      5'd12: value = t3;
      5'd13: value = t4;
      5'd14: value = t5;
      5'd15: value = t6;
      5'd16: value = t7;
      5'd17: value = t8;
      5'd18: value = t9;
      default: value = 32'd0;
    endcase
  end

  assign tick      = (divCnt == LAST_CNT);
  assign frameWrap = tick && (digitIdx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt    <= '0;
      digitIdx  <= 2'd0;
      shown     <= 16'd0;
      shownHalf <= 1'b0;
      shownBad  <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      divCnt <= tick ? '0 : divCnt + 1'b1;
      if (tick) digitIdx <= digitIdx + 2'd1;
      // Inputs are sampled only here, so a frame never mixes two values.
      if (frameWrap) begin
        shown     <= half ? value[31:16] : value[15:0];
        shownHalf <= half;
        shownBad  <= (sel > 5'd18);
      end
      an  <= ~(4'b0001 << digitIdx);
      seg <= shownBad ? 7'b0111111 : hexSeg(shown[{digitIdx, 2'b00} +: 4]);
      dp  <= ~((digitIdx == 2'd3) && shownHalf && !shownBad);
    end
  end

endmodule

// File: tb/tb_single_display.sv
// Directed bench for single_display: a REFRESH_DIV=4 instance for full scan behaviour and a REFRESH_DIV=1 instance for the fastest divider.
module tb_single_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sel;
  logic        half;
  logic [31:0] currentPC, s0, t0, zero32;
  logic [3:0]  an, an1;
  logic [6:0]  seg, seg1;
  logic        dp, dp1;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  always #5 clk = ~clk;

  single_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .half(half), .currentPC(currentPC),
    .s0(s0), .s1(zero32), .s2(zero32), .s3(zero32), .s4(zero32), .s5(zero32), .s6(zero32), .s7(zero32),
    .t0(t0), .t1(zero32), .t2(zero32), .t3(zero32), .t4(zero32), .t5(zero32), .t6(zero32), .t7(zero32),
    .t8(zero32), .t9(zero32), .an(an), .seg(seg), .dp(dp)
  );

  single_display #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .half(half), .currentPC(currentPC),
    .s0(s0), .s1(zero32), .s2(zero32), .s3(zero32), .s4(zero32), .s5(zero32), .s6(zero32), .s7(zero32),
    .t0(t0), .t1(zero32), .t2(zero32), .t3(zero32), .t4(zero32), .t5(zero32), .t6(zero32), .t7(zero32),
    .t8(zero32), .t9(zero32), .an(an1), .seg(seg1), .dp(dp1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the given post-reset rising edge.
  task automatic toEdge(input int e);
    while (edges < e) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg, input logic expDp);
    check({tag, ".an"}, 32'(an), 32'(expAn));
    check({tag, ".seg"}, 32'(seg), 32'(expSeg));
    check({tag, ".dp"}, 32'(dp), 32'(expDp));
  endtask

  task automatic chk1(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg);
    check({tag, ".an"}, 32'(an1), 32'(expAn));
    check({tag, ".seg"}, 32'(seg1), 32'(expSeg));
  endtask

  initial begin
    rst = 1'b1; sel = 5'd0; half = 1'b0; zero32 = 32'd0;
    currentPC = 32'h0040_0010; s0 = 32'd0; t0 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 4'b1111, SEG_OFF, 1'b1);
    chk1("reset1", 4'b1111, SEG_OFF);
    rst = 1'b0;
    edges = 0;

    // First frame after reset always shows zero.
    toEdge(1);  chk("f0d0", 4'b1110, SEG_0, 1'b1); chk1("r1e1", 4'b1110, SEG_0);
    toEdge(2);  chk1("r1e2", 4'b1101, SEG_0);
    toEdge(3);  chk1("r1e3", 4'b1011, SEG_0);
    toEdge(4);  chk1("r1e4", 4'b0111, SEG_0);
    toEdge(5);  chk("f0d1", 4'b1101, SEG_0, 1'b1); chk1("r1e5", 4'b1110, SEG_0);
    toEdge(6);  chk1("r1e6", 4'b1101, SEG_1);
    toEdge(9);  chk("f0d2", 4'b1011, SEG_0, 1'b1);
    toEdge(13); chk("f0d3", 4'b0111, SEG_0, 1'b1);

    // PC low half 0x0010.
    toEdge(17); chk("pc_d0", 4'b1110, SEG_0, 1'b1);
    toEdge(21); chk("pc_d1", 4'b1101, SEG_1, 1'b1);
    toEdge(25); chk("pc_d2", 4'b1011, SEG_0, 1'b1);
    toEdge(29); chk("pc_d3", 4'b0111, SEG_0, 1'b1);

    // s0 high half 0xDEAD with dp on the leftmost digit.
    sel = 5'd1; half = 1'b1; s0 = 32'hDEAD_BEEF;
    toEdge(33); chk("hi_d0", 4'b1110, SEG_D, 1'b1);
    toEdge(37); chk("hi_d1", 4'b1101, SEG_A, 1'b1);
    toEdge(41); chk("hi_d2", 4'b1011, SEG_E, 1'b1);
    toEdge(45); chk("hi_d3", 4'b0111, SEG_D, 1'b0);

    // Invalid select shows dashes and suppresses dp.
    sel = 5'd20;
    toEdge(48); chk("hi_d3_end", 4'b0111, SEG_D, 1'b0);
    toEdge(49); chk("bad_d0", 4'b1110, SEG_DASH, 1'b1);
    toEdge(61); chk("bad_d3", 4'b0111, SEG_DASH, 1'b1);

    sel = 5'd9; half = 1'b0; t0 = 32'h0000_1234;
    toEdge(65); chk("t0_d0", 4'b1110, SEG_4, 1'b1);
    toEdge(69); chk("t0_d1", 4'b1101, SEG_3, 1'b1);
    toEdge(73); chk("t0_d2", 4'b1011, SEG_2, 1'b1);
    toEdge(77); chk("t0_d3", 4'b0111, SEG_1, 1'b1);

    // Changing the source mid-frame must not tear the frame.
    sel = 5'd1; half = 1'b0; s0 = 32'h0000_AAAA;
    toEdge(81); chk("snapA_d0", 4'b1110, SEG_A, 1'b1);
    toEdge(85); chk("snapA_d1", 4'b1101, SEG_A, 1'b1);
    s0 = 32'h0000_5555;
    toEdge(89); chk("snapA_d2", 4'b1011, SEG_A, 1'b1);
    toEdge(93); chk("snapA_d3", 4'b0111, SEG_A, 1'b1);
    toEdge(97); chk("snap5_d0", 4'b1110, SEG_5, 1'b1);
    toEdge(105); chk("snap5_d2", 4'b1011, SEG_5, 1'b1);

    // Reset mid-scan clears the frame; new frame restarts at digit 0 with zeros.
    rst = 1'b1;
    toEdge(106); chk("mid_rst", 4'b1111, SEG_OFF, 1'b1);
    rst = 1'b0;
    toEdge(107); chk("post_d0", 4'b1110, SEG_0, 1'b1);
    toEdge(111); chk("post_d1", 4'b1101, SEG_0, 1'b1);
    toEdge(123); chk("post_wrap", 4'b1110, SEG_5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/single_display.md
Name: single_display

Overview:
- Board-side consumer of the single-cycle CPU's debug outputs: currentPC, s0–s7 and t0–t9.
- Selects one 32-bit value with switches, freezes 16 bits of it once per scan frame, and time-multiplexes those 16 bits as 4 hex digits on a common-anode 7-segment display.
- Instantiated beside single_top in the board wrapper; shares its clk.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit. Must be >=1. Counter width is $clog2(REFRESH_DIV), minimum 1.

Ports:
- clk  input  1  system clock, same net as the CPU clock
- rst  input  1  synchronous, active-high reset
- sel  input  5  source select: 0=currentPC, 1..8=s0..s7, 9..18=t0..t9, 19..31 invalid
- half  input  1  0 = bits [15:0], 1 = bits [31:16]
- currentPC, s0..s7, t0..t9  input  32 each  values from the CPU
- an  output  4  digit enables, active-low; an[0] = rightmost digit
- seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low

Behaviour:
- State registers:
  - div_cnt
  - digit_idx (2 bits)
  - shown (16 bits), shown_half, shown_bad
- Reset, taking effect on the rst edge: div_cnt=0, digit_idx=0, shown=0, shown_half=0, shown_bad=0, an=4'b1111, seg=7'b1111111, dp=1.
- Divider: each non-reset cycle div_cnt increments. At div_cnt==REFRESH_DIV-1:
  - div_cnt returns to 0;
  - digit_idx increments mod 4 (3 wraps to 0).
- Snapshot: on the terminal-count edge where digit_idx==3 (frame wrap), in the same edge:
  - shown <= half ? value[31:16] : value[15:0], where value is the mux of sel;
  - shown_half <= half;
  - shown_bad <= (sel > 18).
  - sel, half and data are not sampled at any other time. There is no tearing within a frame.
  - The first frame after reset always shows 0000.
- Outputs are registered and reflect the pre-edge digit_idx, shown, shown_half and shown_bad (one-cycle latency):
  - an <= ~(4'b0001 << digit_idx).
  - seg <= hex pattern of shown[4*digit_idx+3 : 4*digit_idx], or 7'b0111111 (dash) if shown_bad.
  - dp <= 0 only when digit_idx==3 and shown_half==1 and !shown_bad; otherwise 1.
- Exactly one an bit is low in every non-reset cycle.
- Hex patterns {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- REFRESH_DIV=1: digit_idx advances every cycle; the snapshot is taken every 4 cycles.
- rst asserted mid-frame: the next edge yields the reset values regardless of divider state. There is no partial-frame carry-over.
- sel changing between snapshots has no visible effect until the next frame wrap.

Test Plan:
- Reset: REFRESH_DIV=4, rst=1 for 3 cycles -> an=1111, seg=1111111, dp=1. First edge after release -> an=1110, seg=1000000, dp=1. Digit advances every 4 cycles: an=1101, 1011, 0111, 1110.
- PC low half: sel=0, half=0, currentPC=0x00400010, REFRESH_DIV=4. After the first wrap (cycle 16), one frame reads:
  - an=1110 with seg=1000000;
  - an=1101 with seg=1111001;
  - an=1011 with seg=1000000;
  - an=0111 with seg=1000000;
  - dp=1 throughout.
- High half with dp: sel=1, half=1, s0=0xDEADBEEF. Next frame shows digit0..3 = d(0100001), A(0001000), E(0000110), d(0100001). dp=0 only while an=0111.
- Invalid select: sel=20 -> after the next wrap every digit shows seg=0111111 and dp=1. Returning to sel=9 (t0=0x1234, half=0) -> the following frame shows 4, 3, 2, 1 on an[0..3].
- Snapshot stability: change s0 from 0x0000AAAA to 0x00005555 while digit_idx=1 -> all four digits remain A until the next wrap, then all show 5.
- Reset mid-scan: assert rst for 1 cycle while an=1011 -> the next edge gives an=1111, seg=1111111. After release, the display restarts at an=1110 showing 0.
